tpu_control_sequencer: RTL and testbench

Parametrised instruction sequencer for the TPU datapath. It accepts instructions over a valid/ready handshake and decodes the opcode into one-hot control strobes. It holds multi-cycle operations (MATMUL, SYNC) until they complete, and latches the operand field for the datapath. It sits between the instruction source and the load/store, systolic-array and vector units, and applies back-pressure while an operation is in flight.

---
 rtl/tpu_ctrl_pkg.sv | 37 +++
 rtl/tpu_ctrl_decode.sv | 32 +++
 rtl/tpu_control_sequencer.sv | 146 ++++++++++++++
 tb/tb_tpu_control_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared types for the TPU control sequencer: opcode and state encodings, strobe bundle.
// ST_HALT is present only when CTRL_ILLEGAL_TRAP_EN is defined.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LD        = 3'd0,
    OP_ST        = 3'd1,
    OP_MATMUL    = 3'd2,
    OP_ADD       = 3'd3,
    OP_MUL       = 3'd4,
    OP_BROADCAST = 3'd5,
    OP_SYNC      = 3'd6
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_MM_RUN    = 3'd2,
    ST_SYNC_WAIT = 3'd3
`ifdef CTRL_ILLEGAL_TRAP_EN
    , ST_HALT    = 3'd4
`endif
  } state_e;

  localparam int STB_W = 7;

  typedef struct packed {
    logic load;
    logic store;
    logic matmul;
    logic add;
    logic mul;
    logic broadcast;
    logic sync;
  } strobe_t;

endpackage

// File: rtl/tpu_ctrl_decode.sv
// Combinational opcode decode into a one-hot strobe vector plus a legal flag.
// Opcodes above OP_SYNC (including 7) decode as illegal with no strobe.
module tpu_ctrl_decode
  import tpu_ctrl_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0]  i_op,
  output logic [STB_W-1:0] o_strobe,
  output logic             o_legal
);

  strobe_t w_strobe;

  always_comb begin
    w_strobe = '0;
    o_legal  = 1'b1;
    case (i_op)
      OP_W'(OP_LD):        w_strobe.load      = 1'b1;
      OP_W'(OP_ST):        w_strobe.store     = 1'b1;
      OP_W'(OP_MATMUL):    w_strobe.matmul    = 1'b1;
      OP_W'(OP_ADD):       w_strobe.add       = 1'b1;
      OP_W'(OP_MUL):       w_strobe.mul       = 1'b1;
      OP_W'(OP_BROADCAST): w_strobe.broadcast = 1'b1;
      OP_W'(OP_SYNC):      w_strobe.sync      = 1'b1;
      default:             o_legal            = 1'b0;
    endcase
  end

  assign o_strobe = w_strobe;

endmodule

// File: rtl/tpu_control_sequencer.sv
// TPU instruction sequencer: valid/ready intake, one-hot registered strobes, MATMUL/SYNC hold.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: illegal opcode parks the block in HALT until rst.
module tpu_control_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 3,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [INSTR_W-1:0]      instruction,
  input  logic                    sync_ack,
  output logic                    load,
  output logic                    store,
  output logic                    matmul,
  output logic                    add,
  output logic                    mul,
  output logic                    broadcast,
  output logic                    sync,
  output logic [INSTR_W-OP_W-1:0] operand,
  output logic                    busy,
  output logic                    illegal
);

  localparam int OPD_W = INSTR_W - OP_W;

  state_e                 r_state;
  state_e                 w_state_nxt;
  strobe_t                r_strb;
  strobe_t                w_strb_nxt;
  strobe_t                w_dec;
  logic [STB_W-1:0]       w_dec_vec;
  logic                   w_legal;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_kfield;
  logic [CNT_W-1:0]       w_kcnt;
  logic [OPD_W-1:0]       r_operand;
  logic                   r_illegal;
  logic [OP_W-1:0]        w_op;
  logic                   w_accept;

  assign w_op        = instruction[INSTR_W-1 -: OP_W];
  assign instr_ready = (r_state == ST_IDLE) && !rst;
  assign busy        = (r_state != ST_IDLE);
  assign w_accept    = instr_valid && instr_ready;

  tpu_ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .i_op     (w_op),
    .o_strobe (w_dec_vec),
    .o_legal  (w_legal)
  );

  assign w_dec = strobe_t'(w_dec_vec);

  // Counter holds remaining MATMUL cycles after the current one; K = 0 behaves as K = 1.
  assign w_kfield = instruction[CNT_W-1:0];
  assign w_kcnt   = (w_kfield == '0) ? '0 : w_kfield - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_state_nxt = ST_HALT;
`else
            w_state_nxt = ST_ISSUE;
`endif
          end else if (w_dec.matmul) begin
            w_state_nxt = ST_MM_RUN;
          end else if (w_dec.sync) begin
            w_state_nxt = ST_SYNC_WAIT;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:     w_state_nxt = ST_IDLE;
      ST_MM_RUN:    if (r_cnt == '0) w_state_nxt = ST_IDLE;
      ST_SYNC_WAIT: if (sync_ack) w_state_nxt = ST_IDLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_HALT:      w_state_nxt = ST_HALT;
`endif
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_strb_nxt = '0;
    w_cnt_nxt  = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_legal) begin
          w_strb_nxt = w_dec;
          if (w_dec.matmul) w_cnt_nxt = w_kcnt;
        end
      end
      ST_MM_RUN: begin
        if (r_cnt != '0) begin
          w_strb_nxt.matmul = 1'b1;
          w_cnt_nxt         = r_cnt - CNT_W'(1);
        end
      end
      ST_SYNC_WAIT: w_strb_nxt.sync = !sync_ack;
      default: ;
    endcase
  end

  // Registered outputs; reset clears everything, including the latched operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strb    <= '0;
      r_cnt     <= '0;
      r_operand <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_strb <= w_strb_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_accept) r_operand <= instruction[OPD_W-1:0];
      if (w_accept && !w_legal) r_illegal <= 1'b1;
    end
  end

  assign load      = r_strb.load;
  assign store     = r_strb.store;
  assign matmul    = r_strb.matmul;
  assign add       = r_strb.add;
  assign mul       = r_strb.mul;
  assign broadcast = r_strb.broadcast;
  assign sync      = r_strb.sync;
  assign operand   = r_operand;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_tpu_control_sequencer.sv
// Directed bench for tpu_control_sequencer; expectations follow CTRL_ILLEGAL_TRAP_EN when defined.
module tb_tpu_control_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic        sync_ack;
  logic        load, store, matmul, add, mul, broadcast, sync;
  logic [12:0] operand;
  logic        busy;
  logic        illegal;
  logic [6:0]  strb;

  int n_pass;
  int n_total;

  assign strb = {load, store, matmul, add, mul, broadcast, sync};

  tpu_control_sequencer #(
    .INSTR_W (16),
    .OP_W    (3),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .sync_ack    (sync_ack),
    .load        (load),
    .store       (store),
    .matmul      (matmul),
    .add         (add),
    .mul         (mul),
    .broadcast   (broadcast),
    .sync        (sync),
    .operand     (operand),
    .busy        (busy),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instruction = '0; sync_ack = 1'b0;
    tick(); tick();
    n_total++; if (instr_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", instr_ready); else n_pass++;
    n_total++; if (strb !== 7'b0) $display("FAIL reset_strobes got=%b want=0000000", strb); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_total++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%b want=0", illegal); else n_pass++;
    n_total++; if (operand !== 13'd0) $display("FAIL reset_operand got=%0d want=0", operand); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready_after got=%b want=1", instr_ready); else n_pass++;
  endtask

  task automatic test_ld();
    instruction = 16'h0005; instr_valid = 1'b1;
    tick();
    n_total++; if (strb !== 7'b1000000) $display("FAIL ld_strobe got=%b want=1000000", strb); else n_pass++;
    n_total++; if (operand !== 13'd5) $display("FAIL ld_operand got=%0d want=5", operand); else n_pass++;
    n_total++; if (instr_ready !== 1'b0) $display("FAIL ld_ready_n1 got=%b want=0", instr_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL ld_busy_n1 got=%b want=1", busy); else n_pass++;
    tick();
    n_total++; if (strb !== 7'b0) $display("FAIL ld_strobe_n2 got=%b want=0000000", strb); else n_pass++;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL ld_ready_n2 got=%b want=1", instr_ready); else n_pass++;
    instr_valid = 1'b0;
  endtask

  task automatic test_matmul_k4();
    instruction = 16'h4004; instr_valid = 1'b1;
    tick();
    instruction = 16'h6007;
    for (int j = 1; j <= 4; j++) begin
      n_total++; if (strb !== 7'b0010000) $display("FAIL mm4_strobe cyc=%0d got=%b want=0010000", j, strb); else n_pass++;
      n_total++; if (instr_ready !== 1'b0) $display("FAIL mm4_ready cyc=%0d got=%b want=0", j, instr_ready); else n_pass++;
      tick();
    end
    n_total++; if (matmul !== 1'b0) $display("FAIL mm4_matmul_end got=%b want=0", matmul); else n_pass++;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL mm4_ready_n5 got=%b want=1", instr_ready); else n_pass++;
    n_total++; if (operand !== 13'd4) $display("FAIL mm4_operand_held got=%0d want=4", operand); else n_pass++;
    tick();
    n_total++; if (strb !== 7'b0001000) $display("FAIL mm4_next_add got=%b want=0001000", strb); else n_pass++;
    n_total++; if (operand !== 13'd7) $display("FAIL mm4_next_operand got=%0d want=7", operand); else n_pass++;
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_matmul_k0();
    instruction = 16'h4000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_total++; if (strb !== 7'b0010000) $display("FAIL mm0_strobe got=%b want=0010000", strb); else n_pass++;
    tick();
    n_total++; if (matmul !== 1'b0) $display("FAIL mm0_matmul_end got=%b want=0", matmul); else n_pass++;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL mm0_ready got=%b want=1", instr_ready); else n_pass++;
  endtask

  task automatic test_sync();
    instruction = 16'hC003; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_total++; if (strb !== 7'b0000001) $display("FAIL sync_strobe cyc=%0d got=%b want=0000001", i, strb); else n_pass++;
      n_total++; if (instr_ready !== 1'b0) $display("FAIL sync_ready cyc=%0d got=%b want=0", i, instr_ready); else n_pass++;
      if (i == 4) sync_ack = 1'b1;
      tick();
    end
    sync_ack = 1'b0;
    n_total++; if (sync !== 1'b0) $display("FAIL sync_drop got=%b want=0", sync); else n_pass++;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL sync_ready_after got=%b want=1", instr_ready); else n_pass++;
  endtask

  task automatic test_illegal();
    instruction = 16'hE000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_total++; if (illegal !== 1'b1) $display("FAIL ill_flag got=%b want=1", illegal); else n_pass++;
    n_total++; if (strb !== 7'b0) $display("FAIL ill_strobe got=%b want=0000000", strb); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL ill_busy got=%b want=1", busy); else n_pass++;
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    tick(); tick();
    n_total++; if (instr_ready !== 1'b0) $display("FAIL ill_halt_ready got=%b want=0", instr_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL ill_halt_busy got=%b want=1", busy); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL ill_ready_after_rst got=%b want=1", instr_ready); else n_pass++;
    n_total++; if (illegal !== 1'b0) $display("FAIL ill_cleared got=%b want=0", illegal); else n_pass++;
`else
    n_total++; if (instr_ready !== 1'b1) $display("FAIL ill_ready_n2 got=%b want=1", instr_ready); else n_pass++;
    n_total++; if (illegal !== 1'b1) $display("FAIL ill_sticky got=%b want=1", illegal); else n_pass++;
`endif
    instruction = 16'h6001; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_total++; if (strb !== 7'b0001000) $display("FAIL ill_next_add got=%b want=0001000", strb); else n_pass++;
    n_total++; if (operand !== 13'd1) $display("FAIL ill_next_operand got=%0d want=1", operand); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_matmul();
    instruction = 16'h400A; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    n_total++; if (matmul !== 1'b1) $display("FAIL rstmm_running got=%b want=1", matmul); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (strb !== 7'b0) $display("FAIL rstmm_strobes got=%b want=0000000", strb); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmm_busy got=%b want=0", busy); else n_pass++;
    n_total++; if (operand !== 13'd0) $display("FAIL rstmm_operand got=%0d want=0", operand); else n_pass++;
    n_total++; if (illegal !== 1'b0) $display("FAIL rstmm_illegal got=%b want=0", illegal); else n_pass++;
    n_total++; if (instr_ready !== 1'b0) $display("FAIL rstmm_ready_in_rst got=%b want=0", instr_ready); else n_pass++;
    rst = 1'b0;
    instruction = 16'h8003; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_total++; if (strb !== 7'b0000100) $display("FAIL rstmm_mul got=%b want=0000100", strb); else n_pass++;
    n_total++; if (operand !== 13'd3) $display("FAIL rstmm_mul_operand got=%0d want=3", operand); else n_pass++;
    tick();
    n_total++; if (mul !== 1'b0) $display("FAIL rstmm_mul_end got=%b want=0", mul); else n_pass++;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL rstmm_ready_end got=%b want=1", instr_ready); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_ld();
    test_matmul_k4();
    test_matmul_k0();
    test_sync();
    test_illegal();
    test_reset_mid_matmul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
